// File: rtl/mem_burst_fetcher_pkg.sv
// Shared constants and FSM encoding for the cache miss-path burst fetcher.
// Interface widths here are shared with the miss handler.
package mem_burst_fetcher_pkg;

  localparam int unsigned MemAddrWidth  = 16;
  localparam int unsigned MemDataWidth  = 32;
  localparam int unsigned MemOffsetBits = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRecv = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mem_burst_fetcher_sync_fifo.sv
// Generic synchronous FIFO with registered storage, combinational head read,
// full/empty flags and a synchronous flush. Depth must be a power of two.
module mem_burst_fetcher_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; occupancy tracking alone decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push & ~flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_burst_fetcher.sv
// Cache miss-path burst fetcher: one block request -> one memory burst -> buffered beat stream.
// Optional watchdog abort enabled by defining MEM_FETCH_TIMEOUT_EN.
module mem_burst_fetcher
  import mem_burst_fetcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = MemAddrWidth,
  parameter int unsigned DATA_WIDTH     = MemDataWidth,
  parameter int unsigned OFFSET_BITS    = MemOffsetBits,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ack,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  input  logic                   i_mem_data_valid,
  output logic                   o_mem_data_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_data_valid,
  output logic [OFFSET_BITS-1:0] o_beat_idx,
  output logic                   o_last,
  input  logic                   i_halt,
  output logic                   o_busy,
  output logic                   o_error
);

  localparam logic [OFFSET_BITS-1:0] LastIdx = {OFFSET_BITS{1'b1}};
  localparam logic [OFFSET_BITS:0]   FullCnt = {1'b1, {OFFSET_BITS{1'b0}}};

  fetch_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [OFFSET_BITS:0]     rx_cnt_q, rx_cnt_d;
  logic [OFFSET_BITS-1:0]   idx_q, idx_d;

  logic fifo_full, fifo_empty;
  logic push, pop, accept, last_pop;
  logic timeout, flush;

  logic unused_addr_offset;
  assign unused_addr_offset = ^i_req_addr[OFFSET_BITS-1:0];

  assign o_req_ready      = (state_q == StIdle);
  assign o_busy           = (state_q != StIdle);
  assign o_mem_req_valid  = (state_q == StReq);
  assign o_mem_addr       = base_q;
  assign accept           = o_req_ready & i_req_valid;

  // Ready comes from pre-pop fullness, so a full FIFO never takes a beat even while popping.
  assign o_mem_data_ready = (state_q == StRecv) & ~fifo_full & (rx_cnt_q != FullCnt);
  assign push             = i_mem_data_valid & o_mem_data_ready;

  assign o_data_valid     = ~fifo_empty;
  assign pop              = o_data_valid & ~i_halt;
  assign o_beat_idx       = idx_q;
  assign o_last           = o_data_valid & (idx_q == LastIdx);
  assign last_pop         = pop & o_last & (rx_cnt_q == FullCnt);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rx_cnt_d = rx_cnt_q;
    idx_d    = idx_q;
    if (push) rx_cnt_d = rx_cnt_q + 1'b1;
    if (pop)  idx_d    = idx_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          state_d  = StReq;
          base_d   = {i_req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          rx_cnt_d = '0;
          idx_d    = '0;
        end
      end
      StReq: begin
        if (i_mem_req_ack) state_d = StRecv;
      end
      StRecv: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d  = StIdle;
      rx_cnt_d = '0;
      idx_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      rx_cnt_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rx_cnt_q <= rx_cnt_d;
      idx_q    <= idx_d;
    end
  end

`ifdef MEM_FETCH_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           activity;

  // Any handshake on either side counts as forward progress.
  assign activity = (o_mem_req_valid & i_mem_req_ack) | push | pop;
  assign timeout  = o_busy & ~activity & (wd_q == WdLimit);
  assign flush    = timeout;
  assign o_error  = err_q;

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (o_busy & ~activity & ~timeout) wd_d = wd_q + 1'b1;
    if (timeout)     err_d = 1'b1;
    else if (accept) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout_cfg;
  logic unused_accept;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign unused_accept      = accept;
  assign timeout            = 1'b0;
  assign flush              = 1'b0;
  assign o_error            = 1'b0;
`endif

  mem_burst_fetcher_sync_fifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (arst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (i_mem_data),
    .pop_i   (pop),
    .rdata_o (o_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
